// File: rtl/vexriscv_bus_pkg.sv
// Shared constants, encodings and helpers for the VexRiscv bus bridge.
// Imported by the bridge top and its external-port holding block.
package vexriscv_bus_pkg;

    localparam logic [3:0] EXT_SEL_DEF  = 4'b0111;
    localparam int         PER_PREFIX_W = 24;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    typedef enum logic {
        ST_IDLE,
        ST_EXT_WAIT
    } dstate_e;

    typedef enum logic [1:0] {
        TGT_RAM,
        TGT_PER,
        TGT_EXT,
        TGT_NONE
    } tgt_e;

    function automatic logic [3:0] wmask(
        input logic [1:0] size,
        input logic [1:0] lsb
    );
        logic [3:0] m;
        case (size)
            SZ_BYTE: m = 4'b0001 << lsb;
            SZ_HALF: m = lsb[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic tgt_e decode(
        input logic [31:0] a,
        input logic [3:0]  sel
    );
        tgt_e t;
        if (!a[31])
            t = TGT_RAM;
        else if (&a[31:32-PER_PREFIX_W])
            t = TGT_PER;
        else if ((&a[31:17]) && a[16:13] == sel)
            t = TGT_EXT;
        else
            t = TGT_NONE;
        return t;
    endfunction

endpackage

// File: rtl/vexriscv_ext_port.sv
// Holding registers and timeout counter for one external-bus access.
// The access is held until ext_ready, timeout, or abort.
module vexriscv_ext_port
    import vexriscv_bus_pkg::*;
#(
    parameter int EXT_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        start,
    input  logic        abort,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        ext_ready,
    output logic        ext_cs,
    output logic        ext_oe,
    output logic [3:0]  ext_wstrb,
    output logic [15:0] ext_addr,
    output logic [31:0] ext_wdata,
    output logic        done,
    output logic        expire
);

    localparam logic [15:0] LAST = 16'(EXT_TIMEOUT - 1);

    logic [15:0] cnt;

    // ext_ready wins over the timeout on the final wait cycle
    assign done   = ext_cs && !abort && ext_ready;
    assign expire = ext_cs && !abort && !ext_ready && cnt == LAST;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ext_cs    <= 1'b0;
            ext_oe    <= 1'b0;
            ext_wstrb <= 4'b0;
            ext_addr  <= 16'b0;
            ext_wdata <= 32'b0;
            cnt       <= 16'b0;
        end else if (abort || done || expire) begin
            ext_cs    <= 1'b0;
            ext_oe    <= 1'b0;
            ext_wstrb <= 4'b0;
            cnt       <= 16'b0;
        end else if (start) begin
            ext_cs    <= 1'b1;
            ext_oe    <= !wr;
            ext_wstrb <= wr ? wstrb : 4'b0;
            ext_addr  <= addr;
            ext_wdata <= wdata;
            cnt       <= 16'b0;
        end else if (ext_cs) begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/vexriscv_bus_bridge.sv
// Arbitrates VexRiscv iBus/dBus onto on-chip RAM, peripherals and a
// wait-stated external port; the loader owns the RAM in prog_mode.
module vexriscv_bus_bridge
    import vexriscv_bus_pkg::*;
#(
    parameter int         RAM_ADDR_BITS = 14,
    parameter int         EXT_TIMEOUT   = 255,
    parameter logic [3:0] EXT_SEL       = EXT_SEL_DEF
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     prog_mode,
    input  logic [RAM_ADDR_BITS-1:0] prog_addr,
    input  logic [31:0]              prog_wdata,
    input  logic [3:0]               prog_wstrb,
    output logic [31:0]              prog_rdata,
    input  logic                     ibus_cmd_valid,
    output logic                     ibus_cmd_ready,
    input  logic [31:0]              ibus_cmd_pc,
    output logic                     ibus_rsp_valid,
    output logic                     ibus_rsp_error,
    output logic [31:0]              ibus_rsp_inst,
    input  logic                     dbus_cmd_valid,
    output logic                     dbus_cmd_ready,
    input  logic                     dbus_cmd_wr,
    input  logic [31:0]              dbus_cmd_addr,
    input  logic [31:0]              dbus_cmd_data,
    input  logic [1:0]               dbus_cmd_size,
    output logic                     dbus_rsp_valid,
    output logic                     dbus_rsp_error,
    output logic [31:0]              dbus_rsp_data,
    output logic                     ram_en,
    output logic [RAM_ADDR_BITS-1:0] ram_addr,
    output logic [3:0]               ram_wstrb,
    output logic [31:0]              ram_wdata,
    input  logic [31:0]              ram_rdata,
    output logic                     per_cs,
    output logic                     per_oe,
    output logic [3:0]               per_wstrb,
    output logic [5:0]               per_addr,
    output logic [31:0]              per_wdata,
    input  logic [31:0]              per_rdata,
    output logic                     ext_cs,
    output logic                     ext_oe,
    output logic [3:0]               ext_wstrb,
    output logic [15:0]              ext_addr,
    output logic [31:0]              ext_wdata,
    input  logic [31:0]              ext_rdata,
    input  logic                     ext_ready,
    output logic                     bus_err
);

    logic        run;
    dstate_e     state;
    tgt_e        d_tgt;
    logic [3:0]  d_mask;
    logic        d_acc;
    logic        d_ram;
    logic        i_acc;
    logic        i_ram;
    logic        ext_start;
    logic        ext_done;
    logic        ext_expire;
    logic        i_vld;
    logic        i_err;
    logic        d_vld;
    logic        d_err;
    logic        d_from_ram;
    logic [31:0] d_data;
    logic        unused_pc;

    assign unused_pc = ^ibus_cmd_pc;

    assign d_tgt  = decode(dbus_cmd_addr, EXT_SEL);
    assign d_mask = wmask(dbus_cmd_size, dbus_cmd_addr[1:0]);

    // run holds both buses off for the first cycle out of reset
    assign dbus_cmd_ready = run && !prog_mode && state == ST_IDLE;
    assign d_acc          = dbus_cmd_valid && dbus_cmd_ready;
    assign d_ram          = d_acc && d_tgt == TGT_RAM;
    assign ibus_cmd_ready = run && !prog_mode && !d_ram;
    assign i_acc          = ibus_cmd_valid && ibus_cmd_ready;
    assign i_ram          = i_acc && !ibus_cmd_pc[31];
    assign ext_start      = d_acc && d_tgt == TGT_EXT;

    always_comb begin
        ram_en    = 1'b0;
        ram_addr  = '0;
        ram_wstrb = 4'b0;
        ram_wdata = 32'b0;
        if (run && prog_mode) begin
            ram_en    = 1'b1;
            ram_addr  = prog_addr;
            ram_wstrb = prog_wstrb;
            ram_wdata = prog_wdata;
        end else if (d_ram) begin
            ram_en    = 1'b1;
            ram_addr  = dbus_cmd_addr[RAM_ADDR_BITS+1:2];
            ram_wstrb = dbus_cmd_wr ? d_mask : 4'b0;
            ram_wdata = dbus_cmd_data;
        end else if (i_ram) begin
            ram_en   = 1'b1;
            ram_addr = ibus_cmd_pc[RAM_ADDR_BITS+1:2];
        end
    end

    assign prog_rdata = ram_rdata;

    assign per_cs    = d_acc && d_tgt == TGT_PER;
    assign per_oe    = per_cs && !dbus_cmd_wr;
    assign per_wstrb = (per_cs && dbus_cmd_wr) ? d_mask : 4'b0;
    assign per_addr  = dbus_cmd_addr[7:2];
    assign per_wdata = dbus_cmd_data;

    vexriscv_ext_port #(
        .EXT_TIMEOUT(EXT_TIMEOUT)
    ) u_ext (
        .clk      (clk),
        .nrst     (nrst),
        .start    (ext_start),
        .abort    (prog_mode),
        .wr       (dbus_cmd_wr),
        .addr     (dbus_cmd_addr[15:0]),
        .wdata    (dbus_cmd_data),
        .wstrb    (d_mask),
        .ext_ready(ext_ready),
        .ext_cs   (ext_cs),
        .ext_oe   (ext_oe),
        .ext_wstrb(ext_wstrb),
        .ext_addr (ext_addr),
        .ext_wdata(ext_wdata),
        .done     (ext_done),
        .expire   (ext_expire)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= ST_IDLE;
        end else if (prog_mode) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:
                    if (ext_start)
                        state <= ST_EXT_WAIT;
                ST_EXT_WAIT:
                    if (ext_done || ext_expire)
                        state <= ST_IDLE;
                default:
                    state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            run        <= 1'b0;
            i_vld      <= 1'b0;
            i_err      <= 1'b0;
            d_vld      <= 1'b0;
            d_err      <= 1'b0;
            d_from_ram <= 1'b0;
            d_data     <= 32'b0;
            bus_err    <= 1'b0;
        end else begin
            run        <= 1'b1;
            i_vld      <= i_acc;
            i_err      <= i_acc && ibus_cmd_pc[31];
            d_vld      <= 1'b0;
            d_err      <= 1'b0;
            d_from_ram <= 1'b0;
            d_data     <= 32'b0;
            if (d_acc && !dbus_cmd_wr) begin
                case (d_tgt)
                    TGT_RAM: begin
                        d_vld      <= 1'b1;
                        d_from_ram <= 1'b1;
                    end
                    TGT_PER: begin
                        d_vld  <= 1'b1;
                        d_data <= per_rdata;
                    end
                    TGT_NONE: begin
                        d_vld <= 1'b1;
                        d_err <= 1'b1;
                    end
                    default: ;
                endcase
            end
            if (ext_done && ext_oe) begin
                d_vld  <= 1'b1;
                d_data <= ext_rdata;
            end
            if (ext_expire && ext_oe) begin
                d_vld <= 1'b1;
                d_err <= 1'b1;
            end
            if (ext_expire || (d_acc && dbus_cmd_wr && d_tgt == TGT_NONE))
                bus_err <= 1'b1;
        end
    end

    // outputs are masked the cycle prog_mode rises
    assign ibus_rsp_valid = i_vld && !prog_mode;
    assign ibus_rsp_error = i_err && !prog_mode;
    assign ibus_rsp_inst  = (i_vld && !i_err) ? ram_rdata : 32'b0;
    assign dbus_rsp_valid = d_vld && !prog_mode;
    assign dbus_rsp_error = d_err && !prog_mode;
    assign dbus_rsp_data  = d_from_ram ? ram_rdata : d_data;

endmodule

// File: tb/tb_vexriscv_bus_bridge.sv
// Directed vector table plus hand-written multi-cycle sequences
// for the VexRiscv bus bridge.
module tb_vexriscv_bus_bridge;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        prog_mode = 1'b0;
    logic [13:0] prog_addr = '0;
    logic [31:0] prog_wdata = '0;
    logic [3:0]  prog_wstrb = '0;
    logic [31:0] prog_rdata;
    logic        ibus_cmd_valid = 1'b0;
    logic        ibus_cmd_ready;
    logic [31:0] ibus_cmd_pc = '0;
    logic        ibus_rsp_valid;
    logic        ibus_rsp_error;
    logic [31:0] ibus_rsp_inst;
    logic        dbus_cmd_valid = 1'b0;
    logic        dbus_cmd_ready;
    logic        dbus_cmd_wr = 1'b0;
    logic [31:0] dbus_cmd_addr = '0;
    logic [31:0] dbus_cmd_data = '0;
    logic [1:0]  dbus_cmd_size = '0;
    logic        dbus_rsp_valid;
    logic        dbus_rsp_error;
    logic [31:0] dbus_rsp_data;
    logic        ram_en;
    logic [13:0] ram_addr;
    logic [3:0]  ram_wstrb;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = '0;
    logic        per_cs;
    logic        per_oe;
    logic [3:0]  per_wstrb;
    logic [5:0]  per_addr;
    logic [31:0] per_wdata;
    logic [31:0] per_rdata = '0;
    logic        ext_cs;
    logic        ext_oe;
    logic [3:0]  ext_wstrb;
    logic [15:0] ext_addr;
    logic [31:0] ext_wdata;
    logic [31:0] ext_rdata = '0;
    logic        ext_ready = 1'b0;
    logic        bus_err;

    always #5 clk = ~clk;

    vexriscv_bus_bridge #(
        .RAM_ADDR_BITS(14),
        .EXT_TIMEOUT  (8),
        .EXT_SEL      (4'b0111)
    ) dut (
        .clk           (clk),
        .nrst          (nrst),
        .prog_mode     (prog_mode),
        .prog_addr     (prog_addr),
        .prog_wdata    (prog_wdata),
        .prog_wstrb    (prog_wstrb),
        .prog_rdata    (prog_rdata),
        .ibus_cmd_valid(ibus_cmd_valid),
        .ibus_cmd_ready(ibus_cmd_ready),
        .ibus_cmd_pc   (ibus_cmd_pc),
        .ibus_rsp_valid(ibus_rsp_valid),
        .ibus_rsp_error(ibus_rsp_error),
        .ibus_rsp_inst (ibus_rsp_inst),
        .dbus_cmd_valid(dbus_cmd_valid),
        .dbus_cmd_ready(dbus_cmd_ready),
        .dbus_cmd_wr   (dbus_cmd_wr),
        .dbus_cmd_addr (dbus_cmd_addr),
        .dbus_cmd_data (dbus_cmd_data),
        .dbus_cmd_size (dbus_cmd_size),
        .dbus_rsp_valid(dbus_rsp_valid),
        .dbus_rsp_error(dbus_rsp_error),
        .dbus_rsp_data (dbus_rsp_data),
        .ram_en        (ram_en),
        .ram_addr      (ram_addr),
        .ram_wstrb     (ram_wstrb),
        .ram_wdata     (ram_wdata),
        .ram_rdata     (ram_rdata),
        .per_cs        (per_cs),
        .per_oe        (per_oe),
        .per_wstrb     (per_wstrb),
        .per_addr      (per_addr),
        .per_wdata     (per_wdata),
        .per_rdata     (per_rdata),
        .ext_cs        (ext_cs),
        .ext_oe        (ext_oe),
        .ext_wstrb     (ext_wstrb),
        .ext_addr      (ext_addr),
        .ext_wdata     (ext_wdata),
        .ext_rdata     (ext_rdata),
        .ext_ready     (ext_ready),
        .bus_err       (bus_err)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
        logic [31:0] rd;
        logic [31:0] prd;
        logic        en;
        logic [13:0] ra;
        logic [3:0]  ws;
        logic        pcs;
        logic        poe;
        logic [3:0]  pws;
        logic        rv;
        logic        re;
        logic [31:0] rdat;
    } vec_t;

    vec_t vt[9];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        nrst = 1'b0;
        #2;
        chk("rst_bus_err", {31'b0, bus_err}, 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vt[0] = '{1'b0, 32'h0000_0010, 32'h0, 2'd2, 32'hDEAD_BEEF, 32'h0,
                  1'b1, 14'd4, 4'b0000, 1'b0, 1'b0, 4'b0000,
                  1'b1, 1'b0, 32'hDEAD_BEEF};
        vt[1] = '{1'b1, 32'h0000_0003, 32'h0000_00AB, 2'd0, 32'h0, 32'h0,
                  1'b1, 14'd0, 4'b1000, 1'b0, 1'b0, 4'b0000,
                  1'b0, 1'b0, 32'h0};
        vt[2] = '{1'b1, 32'h0000_0002, 32'hABCD_0000, 2'd1, 32'h0, 32'h0,
                  1'b1, 14'd0, 4'b1100, 1'b0, 1'b0, 4'b0000,
                  1'b0, 1'b0, 32'h0};
        vt[3] = '{1'b1, 32'h0000_0000, 32'h0000_1234, 2'd1, 32'h0, 32'h0,
                  1'b1, 14'd0, 4'b0011, 1'b0, 1'b0, 4'b0000,
                  1'b0, 1'b0, 32'h0};
        vt[4] = '{1'b1, 32'h0000_0004, 32'h0BAD_CAFE, 2'd2, 32'h0, 32'h0,
                  1'b1, 14'd1, 4'b1111, 1'b0, 1'b0, 4'b0000,
                  1'b0, 1'b0, 32'h0};
        vt[5] = '{1'b1, 32'h0000_0001, 32'h0000_CD00, 2'd0, 32'h0, 32'h0,
                  1'b1, 14'd0, 4'b0010, 1'b0, 1'b0, 4'b0000,
                  1'b0, 1'b0, 32'h0};
        vt[6] = '{1'b0, 32'hFFFF_FF08, 32'h0, 2'd2, 32'hDEAD_BEEF,
                  32'hCAFE_F00D, 1'b0, 14'd0, 4'b0000, 1'b1, 1'b1,
                  4'b0000, 1'b1, 1'b0, 32'hCAFE_F00D};
        vt[7] = '{1'b1, 32'hFFFF_FF05, 32'h0000_7700, 2'd0, 32'h0, 32'h0,
                  1'b0, 14'd0, 4'b0000, 1'b1, 1'b0, 4'b0010,
                  1'b0, 1'b0, 32'h0};
        vt[8] = '{1'b0, 32'h8000_0000, 32'h0, 2'd2, 32'hDEAD_BEEF, 32'h0,
                  1'b0, 14'd0, 4'b0000, 1'b0, 1'b0, 4'b0000,
                  1'b1, 1'b1, 32'h0};

        #1;
        chk("rst_dcmd_ready", {31'b0, dbus_cmd_ready}, 32'd0);
        chk("rst_icmd_ready", {31'b0, ibus_cmd_ready}, 32'd0);
        chk("rst_ram_en", {31'b0, ram_en}, 32'd0);
        chk("rst_ext_cs", {31'b0, ext_cs}, 32'd0);
        chk("rst_drsp_valid", {31'b0, dbus_rsp_valid}, 32'd0);
        chk("rst_irsp_valid", {31'b0, ibus_rsp_valid}, 32'd0);
        chk("rst_bus_err", {31'b0, bus_err}, 32'd0);
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            dbus_cmd_valid = 1'b1;
            dbus_cmd_wr    = vt[i].wr;
            dbus_cmd_addr  = vt[i].addr;
            dbus_cmd_data  = vt[i].data;
            dbus_cmd_size  = vt[i].size;
            per_rdata      = vt[i].prd;
            #1;
            chk($sformatf("v%0d_dcmd_ready", i), {31'b0, dbus_cmd_ready}, 32'd1);
            chk($sformatf("v%0d_ram_en", i), {31'b0, ram_en}, {31'b0, vt[i].en});
            if (vt[i].en) begin
                chk($sformatf("v%0d_ram_addr", i), {18'b0, ram_addr},
                    {18'b0, vt[i].ra});
                chk($sformatf("v%0d_ram_wstrb", i), {28'b0, ram_wstrb},
                    {28'b0, vt[i].ws});
                if (vt[i].wr)
                    chk($sformatf("v%0d_ram_wdata", i), ram_wdata, vt[i].data);
            end
            chk($sformatf("v%0d_per_cs", i), {31'b0, per_cs}, {31'b0, vt[i].pcs});
            chk($sformatf("v%0d_per_oe", i), {31'b0, per_oe}, {31'b0, vt[i].poe});
            chk($sformatf("v%0d_per_wstrb", i), {28'b0, per_wstrb},
                {28'b0, vt[i].pws});
            if (vt[i].pcs)
                chk($sformatf("v%0d_per_addr", i), {26'b0, per_addr},
                    {26'b0, vt[i].addr[7:2]});
            @(negedge clk);
            dbus_cmd_valid = 1'b0;
            ram_rdata      = vt[i].rd;
            per_rdata      = 32'h0BAD_0BAD;
            #1;
            chk($sformatf("v%0d_rsp_valid", i), {31'b0, dbus_rsp_valid},
                {31'b0, vt[i].rv});
            if (vt[i].rv) begin
                chk($sformatf("v%0d_rsp_error", i), {31'b0, dbus_rsp_error},
                    {31'b0, vt[i].re});
                chk($sformatf("v%0d_rsp_data", i), dbus_rsp_data, vt[i].rdat);
            end
        end
        chk("tbl_bus_err", {31'b0, bus_err}, 32'd0);

        // dBus RAM read wins over a same-cycle fetch
        @(negedge clk);
        ibus_cmd_valid = 1'b1;
        ibus_cmd_pc    = 32'h0000_0100;
        dbus_cmd_valid = 1'b1;
        dbus_cmd_wr    = 1'b0;
        dbus_cmd_addr  = 32'h0000_0200;
        dbus_cmd_size  = 2'd2;
        #1;
        chk("arb_icmd_ready", {31'b0, ibus_cmd_ready}, 32'd0);
        chk("arb_dcmd_ready", {31'b0, dbus_cmd_ready}, 32'd1);
        chk("arb_ram_addr_d", {18'b0, ram_addr}, 32'h80);
        @(negedge clk);
        dbus_cmd_valid = 1'b0;
        ram_rdata      = 32'h1111_1111;
        #1;
        chk("arb_drsp_valid", {31'b0, dbus_rsp_valid}, 32'd1);
        chk("arb_drsp_data", dbus_rsp_data, 32'h1111_1111);
        chk("arb_irsp_early", {31'b0, ibus_rsp_valid}, 32'd0);
        chk("arb_icmd_ready2", {31'b0, ibus_cmd_ready}, 32'd1);
        chk("arb_ram_addr_i", {18'b0, ram_addr}, 32'h40);
        @(negedge clk);
        ibus_cmd_valid = 1'b0;
        ram_rdata      = 32'h2222_2222;
        #1;
        chk("arb_irsp_valid", {31'b0, ibus_rsp_valid}, 32'd1);
        chk("arb_irsp_error", {31'b0, ibus_rsp_error}, 32'd0);
        chk("arb_irsp_inst", ibus_rsp_inst, 32'h2222_2222);
        chk("arb_drsp_gone", {31'b0, dbus_rsp_valid}, 32'd0);

        // fetch outside RAM
        @(negedge clk);
        ibus_cmd_valid = 1'b1;
        ibus_cmd_pc    = 32'h8000_0000;
        #1;
        chk("ifx_icmd_ready", {31'b0, ibus_cmd_ready}, 32'd1);
        chk("ifx_ram_en", {31'b0, ram_en}, 32'd0);
        @(negedge clk);
        ibus_cmd_valid = 1'b0;
        ram_rdata      = 32'h7777_7777;
        #1;
        chk("ifx_irsp_valid", {31'b0, ibus_rsp_valid}, 32'd1);
        chk("ifx_irsp_error", {31'b0, ibus_rsp_error}, 32'd1);
        chk("ifx_irsp_inst", ibus_rsp_inst, 32'h0);

        // external read, ready on the fifth wait cycle, fetch in between
        @(negedge clk);
        dbus_cmd_valid = 1'b1;
        dbus_cmd_wr    = 1'b0;
        dbus_cmd_addr  = 32'hFFFE_E000;
        dbus_cmd_size  = 2'd2;
        ext_ready      = 1'b0;
        #1;
        chk("xr_dcmd_ready", {31'b0, dbus_cmd_ready}, 32'd1);
        chk("xr_cs_before", {31'b0, ext_cs}, 32'd0);
        n = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            dbus_cmd_valid = 1'b0;
            ibus_cmd_valid = 1'b0;
            if (k == 2) begin
                ibus_cmd_valid = 1'b1;
                ibus_cmd_pc    = 32'h0000_0008;
            end
            if (k == 3) ram_rdata = 32'h3333_3333;
            if (k == 5) begin
                ext_ready = 1'b1;
                ext_rdata = 32'h1234_5678;
            end
            if (k == 6) ext_ready = 1'b0;
            #1;
            if (k == 1) begin
                chk("xr_cs", {31'b0, ext_cs}, 32'd1);
                chk("xr_oe", {31'b0, ext_oe}, 32'd1);
                chk("xr_addr", {16'b0, ext_addr}, 32'hE000);
                chk("xr_wstrb", {28'b0, ext_wstrb}, 32'd0);
            end
            if (k == 2) begin
                chk("xr_icmd_ready", {31'b0, ibus_cmd_ready}, 32'd1);
                chk("xr_ram_addr", {18'b0, ram_addr}, 32'd2);
            end
            if (k == 3) begin
                chk("xr_irsp_valid", {31'b0, ibus_rsp_valid}, 32'd1);
                chk("xr_irsp_inst", ibus_rsp_inst, 32'h3333_3333);
            end
            if (!dbus_cmd_ready) n++;
            else break;
        end
        chk("xr_busy_cycles", n, 32'd5);
        chk("xr_rsp_valid", {31'b0, dbus_rsp_valid}, 32'd1);
        chk("xr_rsp_error", {31'b0, dbus_rsp_error}, 32'd0);
        chk("xr_rsp_data", dbus_rsp_data, 32'h1234_5678);
        chk("xr_cs_after", {31'b0, ext_cs}, 32'd0);

        // unmapped write is dropped and flags bus_err
        @(negedge clk);
        dbus_cmd_valid = 1'b1;
        dbus_cmd_wr    = 1'b1;
        dbus_cmd_addr  = 32'h9000_0000;
        dbus_cmd_size  = 2'd2;
        #1;
        chk("uw_ram_en", {31'b0, ram_en}, 32'd0);
        chk("uw_per_cs", {31'b0, per_cs}, 32'd0);
        @(negedge clk);
        dbus_cmd_valid = 1'b0;
        #1;
        chk("uw_rsp_valid", {31'b0, dbus_rsp_valid}, 32'd0);
        chk("uw_bus_err", {31'b0, bus_err}, 32'd1);
        rst_pulse();

        // external write timeout
        @(negedge clk);
        dbus_cmd_valid = 1'b1;
        dbus_cmd_wr    = 1'b1;
        dbus_cmd_addr  = 32'hFFFE_E004;
        dbus_cmd_data  = 32'h0000_0055;
        dbus_cmd_size  = 2'd2;
        #1;
        chk("tw_dcmd_ready", {31'b0, dbus_cmd_ready}, 32'd1);
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            dbus_cmd_valid = 1'b0;
            #1;
            if (k == 1) begin
                chk("tw_wstrb", {28'b0, ext_wstrb}, 32'hF);
                chk("tw_oe", {31'b0, ext_oe}, 32'd0);
                chk("tw_wdata", ext_wdata, 32'h55);
            end
            if (ext_cs) n++;
            else break;
        end
        chk("tw_cs_cycles", n, 32'd8);
        chk("tw_bus_err", {31'b0, bus_err}, 32'd1);
        chk("tw_rsp_valid", {31'b0, dbus_rsp_valid}, 32'd0);
        chk("tw_dcmd_ready", {31'b0, dbus_cmd_ready}, 32'd1);

        // external read timeout
        @(negedge clk);
        dbus_cmd_valid = 1'b1;
        dbus_cmd_wr    = 1'b0;
        dbus_cmd_addr  = 32'hFFFE_E008;
        ext_rdata      = 32'hAAAA_5555;
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            dbus_cmd_valid = 1'b0;
            #1;
            if (ext_cs) n++;
            else break;
        end
        chk("tr_cs_cycles", n, 32'd8);
        chk("tr_rsp_valid", {31'b0, dbus_rsp_valid}, 32'd1);
        chk("tr_rsp_error", {31'b0, dbus_rsp_error}, 32'd1);
        chk("tr_rsp_data", dbus_rsp_data, 32'h0);

        // prog_mode abandons a pending external access
        @(negedge clk);
        dbus_cmd_valid = 1'b1;
        dbus_cmd_addr  = 32'hFFFE_E010;
        repeat (2) begin
            @(negedge clk);
            dbus_cmd_valid = 1'b0;
            #1;
            chk("pm_cs_wait", {31'b0, ext_cs}, 32'd1);
        end
        @(negedge clk);
        prog_mode  = 1'b1;
        prog_addr  = 14'h123;
        prog_wstrb = 4'hF;
        prog_wdata = 32'hFEED_FACE;
        ram_rdata  = 32'h5A5A_5A5A;
        ext_ready  = 1'b1;
        #1;
        chk("pm_dcmd_ready", {31'b0, dbus_cmd_ready}, 32'd0);
        chk("pm_icmd_ready", {31'b0, ibus_cmd_ready}, 32'd0);
        chk("pm_ram_en", {31'b0, ram_en}, 32'd1);
        chk("pm_ram_addr", {18'b0, ram_addr}, 32'h123);
        chk("pm_ram_wstrb", {28'b0, ram_wstrb}, 32'hF);
        chk("pm_ram_wdata", ram_wdata, 32'hFEED_FACE);
        chk("pm_prog_rdata", prog_rdata, 32'h5A5A_5A5A);
        @(negedge clk);
        #1;
        chk("pm_cs_dropped", {31'b0, ext_cs}, 32'd0);
        chk("pm_rsp_valid", {31'b0, dbus_rsp_valid}, 32'd0);
        @(negedge clk);
        prog_mode  = 1'b0;
        prog_wstrb = 4'h0;
        ext_ready  = 1'b0;
        #1;
        chk("pm_idle_ready", {31'b0, dbus_cmd_ready}, 32'd1);
        chk("pm_rsp_none", {31'b0, dbus_rsp_valid}, 32'd0);
        chk("pm_bus_err_held", {31'b0, bus_err}, 32'd1);
        rst_pulse();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
